// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the configurable UART blocks (uart_rx_cfg
// today, uart_tx_cfg later).
//   uart_rx_state_t : receiver FSM state encoding
//   DEFAULT_CLK_DIV : 2604 clocks per bit, 19200 baud at 50 MHz
//   half_div()      : derives the mid-bit offset from a bit period
//   parity_error()  : parity check over a zero-extended data word
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_rx_state_t;

  localparam int DEFAULT_CLK_DIV = 2604;
  localparam int MAX_DATA_BITS   = 9;

  // The first sample lands half a bit after the start edge so that every
  // later sample falls in the middle of its bit.
  function automatic int half_div(input int clk_div);
    return clk_div / 2;
  endfunction

  localparam int DEFAULT_HALF = half_div(DEFAULT_CLK_DIV);

  // Data narrower than MAX_DATA_BITS is zero-extended by the caller, which
  // leaves the XOR unchanged.
  function automatic logic parity_error(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     par_bit,
                                        input logic                     odd);
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: load/decrement bit-timing counter.
//   clk, rst  : system clock, synchronous active-high reset
//   load_half : restart timing; sample fires HALF cycles after this cycle
//   load_full : restart timing; sample fires CLK_DIV cycles after this cycle
//   sample    : high while the counter sits at zero
// The counter parks at zero when nothing reloads it, so sample stays high
// in that condition; the receiver only acts on it in sampling states.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic load_half,
  input  logic load_full,
  output logic sample
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int HALF  = half_div(CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Loading N-1 makes the zero (sample) cycle fall exactly N cycles after
  // the cycle that requested the load.
  always_comb begin
    cnt_d = cnt_q;
    if (load_half) begin
      cnt_d = HALF_LOAD;
    end else if (load_full) begin
      cnt_d = FULL_LOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with error reporting.
//   clk, rst : system clock, synchronous active-high reset
//   RX       : asynchronous serial input, idle high
//   clr_rdy  : consumer pulse, character taken
//   rx_data  : last completed character (LSB received first)
//   rdy      : character available, held until clr_rdy
//   frm_err  : a stop bit of the rx_data frame sampled low
//   par_err  : parity mismatch on the rx_data frame
//   ovr_err  : sticky, a frame completed while rdy was already set
//   busy     : receiver is not idle
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 ovr_err,
  output logic                 busy
);

  uart_rx_state_t state_q, state_d;

  logic                 rx_meta_q, rx_meta_d;
  logic                 rxs_q, rxs_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 frm_acc_q, frm_acc_d;
  logic                 par_acc_q, par_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rdy_q, rdy_d;
  logic                 frm_err_q, frm_err_d;
  logic                 par_err_q, par_err_d;
  logic                 ovr_err_q, ovr_err_d;

  logic sample;
  logic load_half, load_full;
  logic bit_clr, bit_inc;
  logic shift_en, par_en, stop_en, acc_clr, complete;
  logic last_data, last_stop;

  assign last_data = (bit_cnt_q == 4'(DATA_BITS - 1));
  assign last_stop = (bit_cnt_q == 4'(STOP_BITS - 1));

  uart_baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .load_half(load_half),
    .load_full(load_full),
    .sample   (sample)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A low final stop sample means the line is still low,
  // so the receiver parks in BREAK instead of re-triggering on it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!rxs_q) state_d = ST_START;
      ST_START:  if (sample) state_d = rxs_q ? ST_IDLE : ST_DATA;
      ST_DATA:   if (sample && last_data)
                   state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (sample) state_d = ST_STOP;
      ST_STOP:   if (sample && last_stop)
                   state_d = rxs_q ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rxs_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: baud-timer requests and datapath strobes.
  always_comb begin
    load_half = (state_q == ST_IDLE) && !rxs_q;
    load_full = sample && ((state_q == ST_START) || (state_q == ST_DATA) ||
                           (state_q == ST_PARITY) || (state_q == ST_STOP));
    acc_clr   = sample && (state_q == ST_START);
    shift_en  = sample && (state_q == ST_DATA);
    par_en    = sample && (state_q == ST_PARITY);
    stop_en   = sample && (state_q == ST_STOP);
    bit_clr   = acc_clr || (shift_en && last_data);
    bit_inc   = (shift_en && !last_data) || (stop_en && !last_stop);
    complete  = stop_en && last_stop;
    busy      = (state_q != ST_IDLE);
  end

  // Datapath next values. Completion beats a same-cycle clr_rdy, and an
  // overrun is only flagged when the old character was not taken.
  always_comb begin
    rx_meta_d = RX;
    rxs_d     = rx_meta_q;

    shift_d = shift_q;
    if (shift_en) shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};

    bit_cnt_d = bit_cnt_q;
    if (bit_clr) begin
      bit_cnt_d = 4'd0;
    end else if (bit_inc) begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    par_acc_d = par_acc_q;
    if (acc_clr) begin
      par_acc_d = 1'b0;
    end else if (par_en) begin
      par_acc_d = (PARITY_EN != 0) &&
                  parity_error(MAX_DATA_BITS'(shift_q), rxs_q, 1'(PARITY_ODD));
    end

    frm_acc_d = frm_acc_q;
    if (acc_clr) begin
      frm_acc_d = 1'b0;
    end else if (stop_en && !rxs_q) begin
      frm_acc_d = 1'b1;
    end

    rx_data_d = rx_data_q;
    frm_err_d = frm_err_q;
    par_err_d = par_err_q;
    if (complete) begin
      rx_data_d = shift_q;
      frm_err_d = frm_acc_q | ~rxs_q;
      par_err_d = par_acc_q;
    end

    rdy_d = rdy_q;
    if (complete) begin
      rdy_d = 1'b1;
    end else if (clr_rdy) begin
      rdy_d = 1'b0;
    end

    ovr_err_d = ovr_err_q;
    if (clr_rdy) ovr_err_d = 1'b0;
    if (complete && rdy_q && !clr_rdy) ovr_err_d = 1'b1;
  end

  // Datapath registers; the synchroniser resets to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      shift_q   <= '0;
      bit_cnt_q <= 4'd0;
      par_acc_q <= 1'b0;
      frm_acc_q <= 1'b0;
      rx_data_q <= '0;
      frm_err_q <= 1'b0;
      par_err_q <= 1'b0;
      rdy_q     <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rxs_q     <= rxs_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_acc_q <= par_acc_d;
      frm_acc_q <= frm_acc_d;
      rx_data_q <= rx_data_d;
      frm_err_q <= frm_err_d;
      par_err_q <= par_err_d;
      rdy_q     <= rdy_d;
      ovr_err_q <= ovr_err_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;
  assign par_err = par_err_q;
  assign ovr_err = ovr_err_q;

endmodule
